// File: rtl/psum_acc_drain.sv
// Drains OFIFO psum rows, accumulates len_kij rows per pixel, streams ReLU'd sums (PSUM_SAT_EN: saturating adds).
// Latency: acc update 1 cycle after ofifo_rd; out_data registered, first row 1 cycle into FLUSH.
// Backpressure: ofifo_rd only while ofifo_vld in DRAIN; out_data/out_idx hold while out_valid & !out_ready.
module psum_acc_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len_kij = 9,
  parameter int n_out   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ofifo_vld,
  output logic                       ofifo_rd,
  input  logic [col*psum_bw-1:0]     psum_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [col*psum_bw-1:0]     out_data,
  output logic [$clog2(n_out)-1:0]   out_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = col * psum_bw;
  localparam int PW = $clog2(n_out);
  localparam int KW = $clog2(len_kij);
  localparam logic [PW-1:0] PIX_LAST = PW'(n_out - 1);
  localparam logic [KW-1:0] KIJ_LAST = KW'(len_kij - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, LAST, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pix_q, pix_d, k_q, k_d, pix_d1_q, pix_d1_d, out_idx_q, out_idx_d;
  logic [KW-1:0]   kij_q, kij_d;
  logic            rd_d1_q, rd_d1_d, first_d1_q, first_d1_d, out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [DW-1:0]   acc_q [n_out];
  logic [DW-1:0]   acc_d [n_out];

  function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
    logic [psum_bw-1:0] s;
    s = a + b;
`ifdef PSUM_SAT_EN
    // Same-sign operands producing an opposite-sign result overflowed.
    if ((a[psum_bw-1] == b[psum_bw-1]) && (s[psum_bw-1] != a[psum_bw-1]))
      s = a[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
`endif
    return s;
  endfunction

  function automatic logic [DW-1:0] relu_row(input logic [DW-1:0] row);
    logic [DW-1:0] r;
    r = row;
    for (int i = 0; i < col; i++)
      if (row[psum_bw*i + psum_bw-1]) r[psum_bw*i +: psum_bw] = '0;
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < n_out; p++) acc_d[p] = acc_q[p];
    if (rd_d1_q) begin
      for (int i = 0; i < col; i++)
        acc_d[pix_d1_q][psum_bw*i +: psum_bw] = first_d1_q ? psum_in[psum_bw*i +: psum_bw]
            : lane_add(acc_q[pix_d1_q][psum_bw*i +: psum_bw], psum_in[psum_bw*i +: psum_bw]);
    end
  end

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    kij_d       = kij_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    ofifo_rd    = 1'b0;
    rd_d1_d     = 1'b0;
    pix_d1_d    = pix_q;
    first_d1_d  = (kij_q == '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          pix_d   = '0;
          kij_d   = '0;
          k_d     = '0;
        end
      end
      DRAIN: begin
        ofifo_rd = ofifo_vld;
        if (ofifo_vld) begin
          rd_d1_d = 1'b1;
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            kij_d = kij_q + 1'b1;
            if (kij_q == KIJ_LAST) begin
              kij_d   = '0;
              state_d = LAST;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      LAST: state_d = FLUSH;
      FLUSH: begin
        // First load waits one cycle so the final captured row is in acc.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = relu_row(acc_q[k_q]);
          out_idx_d   = k_q;
        end else if (out_ready) begin
          k_d = k_q + 1'b1;
          if (k_q == PIX_LAST) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            out_data_d = relu_row(acc_q[k_q + 1'b1]);
            out_idx_d  = k_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      kij_q       <= '0;
      k_q         <= '0;
      rd_d1_q     <= 1'b0;
      pix_d1_q    <= '0;
      first_d1_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      kij_q       <= kij_d;
      k_q         <= k_d;
      rd_d1_q     <= rd_d1_d;
      pix_d1_q    <= pix_d1_d;
      first_d1_q  <= first_d1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Accumulator contents are don't-care after reset; every tile overwrites them on kij 0.
  always_ff @(posedge clk) begin
    for (int p = 0; p < n_out; p++) acc_q[p] <= acc_d[p];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
